// File: rtl/sr_latch_driver_pkg.sv
// Shared constants for the gated SR latch driver: FSM encoding, verify timing
// and the elaboration-time cycle clamp.
package sr_latch_driver_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_SETUP  = 3'd1;
  localparam logic [STATE_W-1:0] ST_PULSE  = 3'd2;
  localparam logic [STATE_W-1:0] ST_HOLD   = 3'd3;
  localparam logic [STATE_W-1:0] ST_VERIFY = 3'd4;
  localparam logic [STATE_W-1:0] ST_RESP   = 3'd5;

  // Two cycles for the readback synchronizer to settle plus one compare cycle.
  localparam int unsigned VERIFY_CYC  = 3;
  localparam int unsigned SYNC_STAGES = 2;

  function automatic int unsigned max1(input int unsigned x);
    return (x == 0) ? 1 : x;
  endfunction

endpackage

// File: rtl/sr_latch_driver_if.sv
// Request/completion handshake between a command source and the latch driver.
interface sr_latch_driver_if;

  logic req_valid;
  logic req_ready;
  logic req_data;
  logic done_valid;
  logic done_ready;
  logic done_ok;

  modport master (
    output req_valid, req_data, done_ready,
    input  req_ready, done_valid, done_ok
  );

  modport slave (
    input  req_valid, req_data, done_ready,
    output req_ready, done_valid, done_ok
  );

endinterface

// File: rtl/sr_drv_sync2.sv
// Two-flop synchronizer for the asynchronous latch readback lines.
module sr_drv_sync2
  import sr_latch_driver_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/sr_latch_driver.sv
// Sequences setup / C pulse / hold on a gated NAND SR latch per write request.
// Optional readback check is compiled in with SR_LATCH_DRIVER_VERIFY_EN.
module sr_latch_driver
  import sr_latch_driver_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1,
  parameter int unsigned CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sr_latch_driver_if.slave     bus,
  output logic                 latch_c,
  output logic                 latch_s,
  output logic                 latch_r,
  input  logic                 latch_q,
  input  logic                 latch_qbar
);

  localparam int unsigned SETUP_EFF = max1(SETUP_CYC);
  localparam int unsigned PULSE_EFF = max1(PULSE_CYC);
  localparam int unsigned HOLD_EFF  = max1(HOLD_CYC);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_EFF - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_EFF - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_EFF - 1);

  logic [STATE_W-1:0] state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               c_nxt, s_nxt, r_nxt;
  logic               dv, dv_nxt;
  logic               ok, ok_nxt;

`ifdef SR_LATCH_DRIVER_VERIFY_EN
  localparam logic [CNT_W-1:0] VERIFY_LD = CNT_W'(VERIFY_CYC - 1);

  logic data_q, data_nxt;
  logic q_sync, qbar_sync;

  sr_drv_sync2 u_sync_q (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (latch_q),
    .q     (q_sync)
  );

  sr_drv_sync2 u_sync_qbar (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (latch_qbar),
    .q     (qbar_sync)
  );
`else
  // Readback lines are not consumed when the check is compiled out.
  logic unused_readback;
  assign unused_readback = latch_q ^ latch_qbar;
`endif

  // State, phase counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      latch_c <= 1'b0;
      latch_s <= 1'b0;
      latch_r <= 1'b0;
      dv      <= 1'b0;
      ok      <= 1'b0;
`ifdef SR_LATCH_DRIVER_VERIFY_EN
      data_q  <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      latch_c <= c_nxt;
      latch_s <= s_nxt;
      latch_r <= r_nxt;
      dv      <= dv_nxt;
      ok      <= ok_nxt;
`ifdef SR_LATCH_DRIVER_VERIFY_EN
      data_q  <= data_nxt;
`endif
    end
  end

  // Next-state and next-output logic; S/R only move while C is low.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    c_nxt     = latch_c;
    s_nxt     = latch_s;
    r_nxt     = latch_r;
    dv_nxt    = dv;
    ok_nxt    = ok;
`ifdef SR_LATCH_DRIVER_VERIFY_EN
    data_nxt  = data_q;
`endif

    case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          s_nxt     = bus.req_data;
          r_nxt     = ~bus.req_data;
          c_nxt     = 1'b0;
          cnt_nxt   = SETUP_LD;
          state_nxt = ST_SETUP;
`ifdef SR_LATCH_DRIVER_VERIFY_EN
          data_nxt  = bus.req_data;
`endif
        end
      end

      ST_SETUP: begin
        if (cnt == '0) begin
          c_nxt     = 1'b1;
          cnt_nxt   = PULSE_LD;
          state_nxt = ST_PULSE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end

      ST_PULSE: begin
        if (cnt == '0) begin
          c_nxt     = 1'b0;
          cnt_nxt   = HOLD_LD;
          state_nxt = ST_HOLD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end

      ST_HOLD: begin
        if (cnt == '0) begin
          s_nxt = 1'b0;
          r_nxt = 1'b0;
`ifdef SR_LATCH_DRIVER_VERIFY_EN
          cnt_nxt   = VERIFY_LD;
          state_nxt = ST_VERIFY;
`else
          dv_nxt    = 1'b1;
          ok_nxt    = 1'b1;
          state_nxt = ST_RESP;
`endif
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end

`ifdef SR_LATCH_DRIVER_VERIFY_EN
      ST_VERIFY: begin
        if (cnt == '0) begin
          dv_nxt    = 1'b1;
          ok_nxt    = (q_sync == data_q) && (qbar_sync == ~data_q);
          state_nxt = ST_RESP;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
`endif

      ST_RESP: begin
        if (bus.done_ready) begin
          dv_nxt    = 1'b0;
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        c_nxt     = 1'b0;
        s_nxt     = 1'b0;
        r_nxt     = 1'b0;
        dv_nxt    = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.done_valid = dv;
  assign bus.done_ok    = ok;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver: default-parameter instance plus a clamped
// 0/3/0 instance, each driving a behavioural gated SR latch.
module tb_sr_latch_driver;
  import sr_latch_driver_pkg::*;

`ifdef SR_LATCH_DRIVER_VERIFY_EN
  localparam int VER    = 3;
  localparam bit VER_ON = 1'b1;
`else
  localparam int VER    = 0;
  localparam bit VER_ON = 1'b0;
`endif

  typedef struct {
    bit ok;
    int lat;
  } exp_t;

  exp_t sb_q[$];
  int   ncmp = 0;
  int   nerr = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sr_latch_driver_if ifa ();
  sr_latch_driver_if ifb ();

  logic ca, sa, ra, qa, qba;
  logic cb, sb, rb, qb, qbb;
  logic mq_a = 1'b0;
  logic mq_b = 1'b0;
  bit   stuck_q1 = 1'b0;
  bit   both1    = 1'b0;

  sr_latch_driver dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (ifa.slave),
    .latch_c    (ca),
    .latch_s    (sa),
    .latch_r    (ra),
    .latch_q    (qa),
    .latch_qbar (qba)
  );

  sr_latch_driver #(.SETUP_CYC(0), .PULSE_CYC(3), .HOLD_CYC(0)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (ifb.slave),
    .latch_c    (cb),
    .latch_s    (sb),
    .latch_r    (rb),
    .latch_q    (qb),
    .latch_qbar (qbb)
  );

  // Gated NAND SR latch: transparent to S/R while C is high.
  always @(ca or sa or ra) begin
    if (ca && sa)      mq_a = 1'b1;
    else if (ca && ra) mq_a = 1'b0;
  end
  always @(cb or sb or rb) begin
    if (cb && sb)      mq_b = 1'b1;
    else if (cb && rb) mq_b = 1'b0;
  end

  assign qa  = both1 ? 1'b1 : (stuck_q1 ? 1'b1 : mq_a);
  assign qba = both1 ? 1'b1 : (stuck_q1 ? 1'b0 : ~mq_a);
  assign qb  = mq_b;
  assign qbb = ~mq_b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic f_rdy(input int w); return (w == 0) ? ifa.req_ready  : ifb.req_ready;  endfunction
  function automatic logic f_dv (input int w); return (w == 0) ? ifa.done_valid : ifb.done_valid; endfunction
  function automatic logic f_ok (input int w); return (w == 0) ? ifa.done_ok    : ifb.done_ok;    endfunction
  function automatic logic f_c  (input int w); return (w == 0) ? ca : cb; endfunction
  function automatic logic f_s  (input int w); return (w == 0) ? sa : sb; endfunction
  function automatic logic f_r  (input int w); return (w == 0) ? ra : rb; endfunction

  task automatic drive(input int w, input logic v, input logic d, input logic dr);
    if (w == 0) begin
      ifa.req_valid = v; ifa.req_data = d; ifa.done_ready = dr;
    end else begin
      ifb.req_valid = v; ifb.req_data = d; ifb.done_ready = dr;
    end
  endtask

  // One write: trace C/S/R per cycle against the effective phase lengths,
  // score the completion, stall in RESP, then handshake.
  task automatic run_txn(input int w, input bit d, input bit exp_ok, input int stall);
    exp_t e;
    int   n;
    int   sc;
    int   pc;
    int   lat;
    bit   seen;
    sc  = 1;
    pc  = (w == 0) ? 2 : 3;
    lat = sc + pc + 1 + VER;
    n = 0;
    while (!f_rdy(w) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("req_ready_idle", 32'(f_rdy(w)), 1);
    @(negedge clk); drive(w, 1'b1, d, 1'b0);
    @(posedge clk); #1; drive(w, 1'b0, ~d, 1'b0);
    sb_q.push_back('{ok: exp_ok, lat: lat});
    seen = 1'b0;
    for (int k = 0; k <= lat + 4 && !seen; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      chk("latch_c", 32'(f_c(w)), 32'(k >= sc && k < sc + pc));
      chk("latch_s", 32'(f_s(w)), 32'(d && k < sc + pc + 1));
      chk("latch_r", 32'(f_r(w)), 32'(!d && k < sc + pc + 1));
      chk("req_ready_busy", 32'(f_rdy(w)), 0);
      if (f_dv(w)) begin
        seen = 1'b1;
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("latency", 32'(k), 32'(e.lat));
          chk("done_ok", 32'(f_ok(w)), 32'(e.ok));
        end else begin
          chk("scoreboard_empty", 32'(sb_q.size()), 1);
        end
      end
    end
    if (!seen) begin
      chk("done_timeout", 0, 1);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end
    // Competing request held through RESP and the handshake edge.
    drive(w, 1'b1, ~d, 1'b0);
    repeat (stall) begin
      @(posedge clk); #1;
      chk("dv_hold", 32'(f_dv(w)), 1);
      chk("ready_hold", 32'(f_rdy(w)), 0);
    end
    @(negedge clk); drive(w, 1'b1, ~d, 1'b1);
    @(posedge clk); #1;
    chk("dv_clear", 32'(f_dv(w)), 0);
    chk("ready_after_done", 32'(f_rdy(w)), 1);
    chk("no_accept_s", 32'(f_s(w)), 0);
    chk("no_accept_r", 32'(f_r(w)), 0);
    @(negedge clk); drive(w, 1'b0, 1'b0, 1'b0);
  endtask

  // Latch-side invariants sampled away from the active edge.
  logic               pca = 1'b0, psa = 1'b0, pra = 1'b0;
  logic               pcb = 1'b0, psb = 1'b0, prb = 1'b0;
  logic [STATE_W-1:0] psta = ST_IDLE, pstb = ST_IDLE;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("inv_sr_a", 32'(sa & ra), 0);
      chk("inv_sr_b", 32'(sb & rb), 0);
      if (pca) begin
        chk("inv_s_stable_a", 32'(sa), 32'(psa));
        chk("inv_r_stable_a", 32'(ra), 32'(pra));
      end
      if (pcb) begin
        chk("inv_s_stable_b", 32'(sb), 32'(psb));
        chk("inv_r_stable_b", 32'(rb), 32'(prb));
      end
      if (ca && !pca) chk("inv_c_rise_a", 32'(psta), 32'(ST_SETUP));
      if (cb && !pcb) chk("inv_c_rise_b", 32'(pstb), 32'(ST_SETUP));
    end
    pca <= ca; psa <= sa; pra <= ra;
    pcb <= cb; psb <= sb; prb <= rb;
    psta <= dut_a.state;
    pstb <= dut_b.state;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0);
    #12;
    chk("rst_c", 32'(ca), 0);
    chk("rst_s", 32'(sa), 0);
    chk("rst_r", 32'(ra), 0);
    chk("rst_dv", 32'(ifa.done_valid), 0);
    chk("rst_ok", 32'(ifa.done_ok), 0);
    chk("rst_dv_b", 32'(ifb.done_valid), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(ifa.req_ready), 1);
    repeat (7) @(posedge clk);

    // Set, then reset with readback of the latch model.
    run_txn(0, 1'b1, 1'b1, 0);
    run_txn(0, 1'b0, 1'b1, 0);
    chk("model_q", 32'(qa), 0);
    chk("model_qbar", 32'(qba), 1);

    // Faulty latch readback: only the verify build can notice.
    stuck_q1 = 1'b1;
    run_txn(0, 1'b0, !VER_ON, 0);
    stuck_q1 = 1'b0;
    both1 = 1'b1;
    run_txn(0, 1'b1, !VER_ON, 0);
    both1 = 1'b0;

    // Back-pressured completion.
    run_txn(0, 1'b1, 1'b1, 5);

    // Asynchronous reset while C is high.
    @(negedge clk); drive(0, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1; drive(0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("c_before_rst", 32'(ca), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_c", 32'(ca), 0);
    chk("midrst_s", 32'(sa), 0);
    chk("midrst_r", 32'(ra), 0);
    chk("midrst_dv", 32'(ifa.done_valid), 0);
    @(negedge clk); #1; rst_n = 1'b1;
    run_txn(0, 1'b1, 1'b1, 0);

    // done_ready high while idle is ignored.
    @(negedge clk); drive(0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_dr_ready", 32'(ifa.req_ready), 1);
    chk("idle_dr_dv", 32'(ifa.done_valid), 0);
    @(negedge clk); drive(0, 1'b0, 1'b0, 1'b0);

    // Clamped 0/3/0 instance: directed then random back-to-back traffic.
    run_txn(1, 1'b1, 1'b1, 0);
    run_txn(1, 1'b0, 1'b1, 1);
    for (int i = 0; i < 8; i++) begin
      run_txn(1, 1'($urandom_range(0, 1)), 1'b1, int'($urandom_range(0, 2)));
    end

    chk("sb_drained", 32'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Synchronous command sequencer that drives a gated (C/S/R) NAND SR latch from the clocked domain.
- Converts a single-bit write request into a glitch-free S/R setup, C pulse and hold sequence, so that S and R are never both high and S/R never change while C is high.
- Returns a completion response. It is the initiator side of the latch interface: it drives C/S/R and optionally reads back Q/Qbar.

Parameters:
- SETUP_CYC, 1, cycles S/R are stable with C low before the C pulse; 0 is treated as 1.
- PULSE_CYC, 2, cycles C is held high; 0 is treated as 1.
- HOLD_CYC, 1, cycles S/R are held with C low after the pulse; 0 is treated as 1.
- CNT_W, 4, phase counter width; every *_CYC value must be at most 2^CNT_W-1.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  write request valid.
- req_ready  out  1  driver can accept a request.
- req_data  in  1  1 = set latch (S pulse), 0 = reset latch (R pulse).
- done_valid  out  1  operation complete; held until accepted.
- done_ready  in  1  consumer accepts the completion.
- done_ok  out  1  readback matched the request; constant 1 when verify is compiled out.
- latch_c  out  1  to latch C.
- latch_s  out  1  to latch S.
- latch_r  out  1  to latch R.
- latch_q  in  1  from latch Q; asynchronous.
- latch_qbar  in  1  from latch Qbar; asynchronous.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE; latch_c=0, latch_s=0, latch_r=0.
  - done_valid=0, done_ok=0; req_ready=1 after rst_n deasserts.
  - Reset mid-operation drops C, S and R in the same instant; latch content is then unspecified and the bench must not check it.
- All outputs are registered; there is no combinational path from inputs to outputs except req_ready = (state==IDLE).
- FSM states: IDLE, SETUP, PULSE, HOLD, VERIFY, RESP.
- IDLE:
  - req_valid & req_ready accepted at edge t.
  - From t: latch_s=req_data, latch_r=~req_data, latch_c=0; load counter; go to SETUP.
- SETUP: SETUP_CYC cycles, then latch_c=1 and go to PULSE.
- PULSE: PULSE_CYC cycles with C high, then latch_c=0 and go to HOLD; S/R are unchanged.
- HOLD:
  - Lasts HOLD_CYC cycles.
  - On exit, latch_s=latch_r=0 in the same edge.
  - Next state is VERIFY if the feature is enabled, else RESP.
- RESP:
  - done_valid=1, done_ok stable.
  - On done_valid & done_ready, done_valid=0 and return to IDLE; req_ready rises the following cycle.
  - A request cannot be accepted in the same cycle as a completion.
- Latency without verify: done_valid is visible SETUP_CYC+PULSE_CYC+HOLD_CYC edges after the accept edge (defaults: 4).
- Invariants, checked by assertions:
  - never latch_s & latch_r;
  - latch_s and latch_r never change while latch_c=1;
  - latch_c only rises from SETUP.
- Back-pressure: while state≠IDLE, req_ready=0; req_valid and req_data are ignored.
- done_ready held high while in IDLE has no effect.
- Counter counts down from (CYC-1) to 0 and never wraps; clamped values are computed at elaboration.

Optional Feature:
- Macro: SR_LATCH_DRIVER_VERIFY_EN.
- Defined:
  - latch_q and latch_qbar pass through a 2-flop synchronizer.
  - VERIFY lasts exactly 3 cycles (2 cycles synchronizer settle, 1 cycle compare).
  - done_ok = (q_sync==req_data) & (qbar_sync==~req_data); q_sync==qbar_sync gives done_ok=0.
  - Default latency becomes 7.
- Undefined: VERIFY and the synchronizer are absent; done_ok is constant 1 whenever done_valid=1 (0 after reset); latch_q and latch_qbar are unused.

Decomposition:
- Package sr_latch_driver_pkg:
  - state enum (3-bit encoding);
  - VERIFY_CYC=3 and SYNC_STAGES=2;
  - clamp function max1(x).
- One sub-module, sr_drv_sync2: 2-flop synchronizer with async active-low reset to 0. It is instantiated twice and only under the macro.

Test Plan:
- Reset then req_data=1 accepted at cycle 10 (defaults) -> latch_s=1 cycles 10-13, latch_c=1 cycles 11-12, done_valid=1 at cycle 14, latch_r=0 throughout.
- req_data=0 with a behavioural latch model, verify enabled -> latch_r pulse, Q=0/Qbar=1, done_valid at accept+7 with done_ok=1.
- Verify enabled, latch model forced stuck at Q=1 on a reset request -> done_ok=0; forced Q=Qbar=1 -> done_ok=0.
- done_ready held low 5 cycles in RESP -> done_valid stays 1, req_ready stays 0, a second request is not accepted until the cycle after the done handshake.
- rst_n pulled low during PULSE -> latch_c, latch_s, latch_r and done_valid are 0 before the next clk edge; after release, a fresh req_data=1 completes normally.
- SETUP_CYC=0, PULSE_CYC=3, HOLD_CYC=0 -> effective 1/3/1 cycles, latency 5; random back-to-back traffic never violates the S&R or C-stable assertions.
